bcrypt_sequencer: RTL

BCRYPT_SEQUENCER -- requirements
Module: bcrypt_sequencer

---
 rtl/bcrypt_pkg.sv | 30 +++
 rtl/bcrypt_phase_timer.sv | 27 ++
 rtl/bcrypt_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/bcrypt_pkg.sv
// bcrypt_pkg: shared state, start-code and done-code encodings for the bcrypt batch sequencer
package bcrypt_pkg;

    localparam int MAX_CORES = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_STORE  = 3'd4;
    localparam logic [2:0] ST_FINISH = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd6;

    localparam logic [1:0] START_IDLE  = 2'd0;
    localparam logic [1:0] START_LOAD  = 2'd1;
    localparam logic [1:0] START_RUN   = 2'd2;
    localparam logic [1:0] START_STORE = 2'd3;

    localparam logic [7:0] DONE_LOAD  = 8'h01;
    localparam logic [7:0] DONE_RUN   = 8'h02;
    localparam logic [7:0] DONE_STORE = 8'hFF;

    // FINISH keeps the store code so cores hold their results until ack
    function automatic logic [1:0] start_code(input logic [2:0] st);
        return (st == ST_LOAD)                        ? START_LOAD  :
               (st == ST_RUN)                         ? START_RUN   :
               (st == ST_STORE || st == ST_FINISH)    ? START_STORE : START_IDLE;
    endfunction

endpackage

// File: rtl/bcrypt_phase_timer.sv
// bcrypt_phase_timer: per-phase cycle counter; expired flags the last allowed cycle of a phase
module bcrypt_phase_timer #(
    parameter logic [31:0] TIMEOUT = 32'h0FFF_FFFF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [31:0] count;

    // count cycles spent in the current phase, restarting on every phase entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && count != 32'hFFFF_FFFF)
            count <= count + 32'd1;
    end

    // count holds the cycles already elapsed, so TIMEOUT-1 marks the TIMEOUT-th cycle
    assign expired = enable && (count >= TIMEOUT - 32'd1);

endmodule

// File: rtl/bcrypt_sequencer.sv
// bcrypt_sequencer: steps a set of bcrypt loop cores through clear/load/run/store for one batch
module bcrypt_sequencer
    import bcrypt_pkg::*;
#(
    parameter int          NUM_CORES  = 4,
    parameter logic [31:0] TIMEOUT    = 32'h0FFF_FFFF,
    parameter int          CLR_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   go,
    input  logic [NUM_CORES-1:0]   core_mask,
    input  logic                   ack,
    input  logic                   abort,
    output logic [2*NUM_CORES-1:0] start_o,
    input  logic [8*NUM_CORES-1:0] done_i,
    output logic                   busy,
    output logic                   irq,
    output logic                   error,
    output logic [2:0]             phase,
    output logic [31:0]            cycles
);

    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    logic [2:0]           state, state_nxt;
    logic [NUM_CORES-1:0] mask;
    logic [CW-1:0]        clr_cnt;
    logic                 all_load, all_run, all_store;
    logic                 in_phase, expired;
    logic [1:0]           code;

    assign in_phase = (state == ST_LOAD) || (state == ST_RUN) || (state == ST_STORE);
    assign code     = start_code(state);
    assign busy     = state != ST_IDLE;
    assign irq      = (state == ST_FINISH) || (state == ST_ERROR);
    assign phase    = state;

    // all-done reduction over enabled cores; disabled cores never block progress
    always_comb begin
        all_load  = 1'b1;
        all_run   = 1'b1;
        all_store = 1'b1;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (mask[i]) begin
                all_load  = all_load  & (done_i[8*i +: 8] == DONE_LOAD);
                all_run   = all_run   & (done_i[8*i +: 8] == DONE_RUN);
                all_store = all_store & (done_i[8*i +: 8] == DONE_STORE);
            end
        end
    end

    // start code fan-out; disabled cores stay parked at 0
    always_comb begin
        start_o = '0;
        for (int i = 0; i < NUM_CORES; i++)
            start_o[2*i +: 2] = mask[i] ? code : START_IDLE;
    end

    // next state: advance beats timeout, abort beats everything outside IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   state_nxt = (go && |core_mask) ? ST_CLEAR : ST_IDLE;
            ST_CLEAR:  state_nxt = (clr_cnt == CW'(CLR_CYCLES - 1)) ? ST_LOAD : ST_CLEAR;
            ST_LOAD:   state_nxt = all_load  ? ST_RUN    : expired ? ST_ERROR : ST_LOAD;
            ST_RUN:    state_nxt = all_run   ? ST_STORE  : expired ? ST_ERROR : ST_RUN;
            ST_STORE:  state_nxt = all_store ? ST_FINISH : expired ? ST_ERROR : ST_STORE;
            ST_FINISH,
            ST_ERROR:  state_nxt = ack ? ST_IDLE : state;
            default:   state_nxt = ST_IDLE;
        endcase
        if (abort && state != ST_IDLE)
            state_nxt = ST_IDLE;
    end

    // state, latched mask, sticky error, clear-hold counter and batch cycle count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            mask    <= '0;
            error   <= 1'b0;
            cycles  <= '0;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= (state == ST_CLEAR) ? clr_cnt + CW'(1) : '0;
            if (state == ST_IDLE && go) begin
                if (|core_mask) begin
                    mask   <= core_mask;
                    error  <= 1'b0;
                    cycles <= '0;
                end else begin
                    error  <= 1'b1;
                end
            end
            if (state_nxt == ST_ERROR && state != ST_ERROR)
                error <= 1'b1;
            if (in_phase && cycles != 32'hFFFF_FFFF)
                cycles <= cycles + 32'd1;
        end
    end

    bcrypt_phase_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_nxt != state),
        .enable  (in_phase),
        .expired (expired)
    );

endmodule
